pwm_nonoverlap_drv: RTL and testbench
=====================================

Name: pwm_nonoverlap_drv

Overview:
Downstream stage of the 11-bit PWM generator in the motor-drive path. Converts the single PWM_sig into complementary high-side/low-side gate drives with programmable dead time. Suppresses pulses shorter than the dead time. Implements a period-counted over-current shutdown using the generator's PWM_synch and OVR_I_blank_n outputs.

Parameters:
DEAD, 32, dead-time length in clk cycles (>=1); both gates are low for exactly this many cycles on every transition.
OVR_LIMIT, 4, number of consecutive PWM periods containing an over-current event that trips the fault latch (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
PWM_sig  in  1  raw PWM from generator, synchronous to clk
PWM_synch  in  1  single-cycle pulse at end of each PWM period (counter all ones)
OVR_I_blank_n  in  1  high when over-current sampling is valid in the current period
OVR_I  in  1  over-current comparator, asynchronous to clk
clr_fault  in  1  single-cycle fault clear request
high_out  out  1  high-side gate drive, registered
low_out  out  1  low-side gate drive, registered
fault  out  1  over-current fault latched, registered
ovr_cnt  out  $clog2(OVR_LIMIT+1)  current consecutive over-current period count

Behaviour:
- Reset: high_out=0, low_out=0, fault=0, ovr_cnt=0, prev_pwm=0, OVR_I sync flops=0, period flag=0, state=DEAD, dead_cnt=0.
- Invariant: high_out and low_out are never 1 simultaneously, in any state or cycle.
- prev_pwm <= PWM_sig every cycle, in all states. chg = PWM_sig ^ prev_pwm.
- OVR_I passes through a 2-flop synchronizer to give oc_s. oc_evt = oc_s & OVR_I_blank_n & high_out.
- States: DEAD, DRIVE, FAULT, REARM.
- DRIVE:
  - high_out <= PWM_sig; low_out <= ~PWM_sig.
  - On chg: both outputs <= 0 on that edge, dead_cnt <= 0, go to DEAD.
- DEAD:
  - Both outputs held 0.
  - On chg: dead_cnt <= 0 (restart).
  - Else if dead_cnt == DEAD-1: go to DRIVE and load outputs from PWM_sig on that edge.
  - Else dead_cnt++.
  - Net effect: a PWM_sig change sampled at edge n gives both gates low at edges n..n+DEAD-1 and the new gate high at edge n+DEAD. Any level held shorter than DEAD cycles is never driven.
- Over-current counting (DEAD/DRIVE only):
  - Period flag sets on oc_evt.
  - On PWM_synch: if (flag | oc_evt) then ovr_cnt++ (saturate at OVR_LIMIT), else ovr_cnt <= 0. Flag clears.
  - If the incremented value equals OVR_LIMIT: on that same edge go to FAULT, fault <= 1, both outputs <= 0.
- FAULT:
  - Outputs 0 and fault=1. PWM_sig changes are ignored; prev_pwm still tracks.
  - clr_fault: fault <= 0, ovr_cnt <= 0, flag <= 0, go to REARM.
- REARM:
  - Outputs 0.
  - On PWM_synch: dead_cnt <= 0, go to DEAD, so a full dead time elapses before the first drive.
  - clr_fault here has no further effect.
- clr_fault in DEAD/DRIVE: ovr_cnt <= 0 and flag <= 0. It has priority over a coincident PWM_synch increment.
- Simultaneous PWM_synch and chg in DRIVE: both take effect. A resulting trip overrides the DEAD transition (goes to FAULT).
- Async reset mid-operation returns to the reset state immediately. The output drives go low without waiting for clk.

Test Plan:
- DEAD=4, PWM_sig 0->1 sampled at edge 10 -> low_out falls at edge 10, high_out rises at edge 14, both 0 at edges 10-13. Mirror case for 1->0.
- DEAD=4, PWM_sig high for 3 cycles then low -> high_out never asserts; low_out stays 0 until 4 cycles after the falling edge.
- OVR_LIMIT=4, OVR_I high while high_out=1 and blank_n=1 in 4 consecutive periods -> ovr_cnt 1,2,3, then fault=1 and both outputs 0 at the 4th PWM_synch.
- OVR_I pulses in periods 1, 2, 4 only -> ovr_cnt 1, 2, 0, 1; no fault. OVR_I high only while blank_n=0 -> ovr_cnt stays 0.
- In FAULT, pulse clr_fault -> fault=0 next edge, outputs stay 0 until the next PWM_synch + DEAD cycles, then track PWM_sig.
- Random PWM_sig/OVR_I with rst_n pulsed mid-dead-time -> assertion: never high_out & low_out; all outputs 0 during reset.

Source files
------------

// File: rtl/pwm_nonoverlap_drv.sv
// Complementary high/low gate driver with programmable dead time, short-pulse
// suppression and a period-counted over-current fault latch.
module pwm_nonoverlap_drv #(
    parameter int DEAD      = 32,
    parameter int OVR_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           PWM_sig,
    input  logic                           PWM_synch,
    input  logic                           OVR_I_blank_n,
    input  logic                           OVR_I,
    input  logic                           clr_fault,
    output logic                           high_out,
    output logic                           low_out,
    output logic                           fault,
    output logic [$clog2(OVR_LIMIT+1)-1:0] ovr_cnt
);

    localparam int CW = $clog2(OVR_LIMIT + 1);
    localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;

    typedef enum logic [1:0] {
        ST_DEAD,
        ST_DRIVE,
        ST_FAULT,
        ST_REARM
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_dead_cnt;
    logic            r_prev_pwm;
    logic            r_oc_meta;
    logic            r_oc_sync;
    logic            r_flag;

    logic            w_chg;
    logic            w_oc_evt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_trip;

    assign w_chg     = PWM_sig ^ r_prev_pwm;
    assign w_oc_evt  = r_oc_sync & OVR_I_blank_n & high_out;
    assign w_cnt_inc = (ovr_cnt == CW'(OVR_LIMIT)) ? ovr_cnt : ovr_cnt + 1'b1;
    // A trip needs this period to count and the count to land on the limit.
    assign w_trip    = ((r_state == ST_DEAD) || (r_state == ST_DRIVE)) && !clr_fault
                       && PWM_synch && (r_flag || w_oc_evt)
                       && (w_cnt_inc == CW'(OVR_LIMIT));

    // NOTE: every state register uses <= so all next-state terms see pre-edge values;
    // the asynchronous reset drops both gates without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_DEAD;
            r_dead_cnt <= '0;
            r_prev_pwm <= 1'b0;
            r_oc_meta  <= 1'b0;
            r_oc_sync  <= 1'b0;
            r_flag     <= 1'b0;
            high_out   <= 1'b0;
            low_out    <= 1'b0;
            fault      <= 1'b0;
            ovr_cnt    <= '0;
        end else begin
            r_prev_pwm <= PWM_sig;
            r_oc_meta  <= OVR_I;
            r_oc_sync  <= r_oc_meta;

            case (r_state)
                ST_DEAD, ST_DRIVE: begin
                    if (clr_fault) begin
                        ovr_cnt <= '0;
                        r_flag  <= 1'b0;
                    end else if (PWM_synch) begin
                        ovr_cnt <= (r_flag || w_oc_evt) ? w_cnt_inc : '0;
                        r_flag  <= 1'b0;
                    end else if (w_oc_evt) begin
                        r_flag <= 1'b1;
                    end

                    if (w_trip) begin
                        r_state  <= ST_FAULT;
                        fault    <= 1'b1;
                        high_out <= 1'b0;
                        low_out  <= 1'b0;
                    end else if (w_chg) begin
                        r_state    <= ST_DEAD;
                        r_dead_cnt <= '0;
                        high_out   <= 1'b0;
                        low_out    <= 1'b0;
                    end else if ((r_state == ST_DRIVE) || (r_dead_cnt == DW'(DEAD - 1))) begin
                        r_state  <= ST_DRIVE;
                        high_out <= PWM_sig;
                        low_out  <= ~PWM_sig;
                    end else begin
                        r_dead_cnt <= r_dead_cnt + 1'b1;
                        high_out   <= 1'b0;
                        low_out    <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    high_out <= 1'b0;
                    low_out  <= 1'b0;
                    if (clr_fault) begin
                        fault   <= 1'b0;
                        ovr_cnt <= '0;
                        r_flag  <= 1'b0;
                        r_state <= ST_REARM;
                    end
                end

                ST_REARM: begin
                    high_out <= 1'b0;
                    low_out  <= 1'b0;
                    // Re-entry aligns to a period boundary and then waits a full dead time.
                    if (PWM_synch) begin
                        r_dead_cnt <= '0;
                        r_state    <= ST_DEAD;
                    end
                end

                default: begin
                    r_state  <= ST_DEAD;
                    high_out <= 1'b0;
                    low_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_nonoverlap_drv.sv
// Self-checking bench for pwm_nonoverlap_drv: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pwm_nonoverlap_drv;

    localparam int DEAD      = 4;
    localparam int OVR_LIMIT = 4;
    localparam int CW        = $clog2(OVR_LIMIT + 1);

    localparam int M_NORMAL = 0;
    localparam int M_FAULT  = 1;
    localparam int M_REARM  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          PWM_sig = 1'b0;
    logic          PWM_synch = 1'b0;
    logic          OVR_I_blank_n = 1'b1;
    logic          OVR_I = 1'b0;
    logic          clr_fault = 1'b0;
    logic          high_out;
    logic          low_out;
    logic          fault;
    logic [CW-1:0] ovr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pwm_nonoverlap_drv #(.DEAD(DEAD), .OVR_LIMIT(OVR_LIMIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PWM_sig       (PWM_sig),
        .PWM_synch     (PWM_synch),
        .OVR_I_blank_n (OVR_I_blank_n),
        .OVR_I         (OVR_I),
        .clr_fault     (clr_fault),
        .high_out      (high_out),
        .low_out       (low_out),
        .fault         (fault),
        .ovr_cnt       (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a gate is driven once the input level has been stable
    // for DEAD edges since the last change (or since reset / re-arm).
    logic m_high, m_low, m_fault, m_flag, m_prev;
    int   m_cnt, m_since, m_mode;
    logic oc_hist [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_high = 0; m_low = 0; m_fault = 0; m_flag = 0; m_prev = 0;
            m_cnt = 0; m_since = 0; m_mode = M_NORMAL;
            oc_hist[0] = 0; oc_hist[1] = 0;
        end else begin
            logic chg, oc_evt, trip;
            chg    = PWM_sig ^ m_prev;
            oc_evt = oc_hist[1] & OVR_I_blank_n & m_high;
            trip   = 0;
            if (m_mode == M_NORMAL) begin
                if (clr_fault) begin
                    m_cnt = 0; m_flag = 0;
                end else if (PWM_synch) begin
                    if (m_flag || oc_evt) begin
                        m_cnt = (m_cnt + 1 > OVR_LIMIT) ? OVR_LIMIT : m_cnt + 1;
                        trip  = (m_cnt == OVR_LIMIT);
                    end else begin
                        m_cnt = 0;
                    end
                    m_flag = 0;
                end else if (oc_evt) begin
                    m_flag = 1;
                end
                if (trip) begin
                    m_mode = M_FAULT; m_fault = 1; m_high = 0; m_low = 0;
                end else begin
                    if (chg) m_since = 0;
                    else if (m_since < DEAD) m_since++;
                    m_high = (m_since >= DEAD) ? PWM_sig : 1'b0;
                    m_low  = (m_since >= DEAD) ? ~PWM_sig : 1'b0;
                end
            end else if (m_mode == M_FAULT) begin
                m_high = 0; m_low = 0;
                if (clr_fault) begin
                    m_fault = 0; m_cnt = 0; m_flag = 0; m_mode = M_REARM;
                end
            end else begin
                m_high = 0; m_low = 0;
                if (PWM_synch) begin
                    m_since = 0; m_mode = M_NORMAL;
                end
            end
            m_prev     = PWM_sig;
            oc_hist[1] = oc_hist[0];
            oc_hist[0] = OVR_I;
        end
    end

    always @(negedge clk) begin
        check("model_high", high_out, m_high);
        check("model_low", low_out, m_low);
        check("model_fault", fault, m_fault);
        check("model_ovr_cnt", ovr_cnt, m_cnt);
        check("no_overlap", high_out & low_out, 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gates(input string name, input logic h, input logic l);
        check({name, "_high"}, high_out, h);
        check({name, "_low"}, low_out, l);
    endtask

    // One PWM period: over-current asserted early, synch on the last cycle.
    task automatic period(input logic oc, input logic clr_at_synch);
        OVR_I = oc;
        step(5);
        OVR_I = 1'b0;
        step(4);
        PWM_synch = 1'b1;
        clr_fault = clr_at_synch;
        step(1);
        PWM_synch = 1'b0;
        clr_fault = 1'b0;
    endtask

    initial begin
        int run_left;
        step(3);
        gates("reset", 0, 0);
        check("reset_fault", fault, 0);
        check("reset_cnt", ovr_cnt, 0);
        rst_n = 1'b1;

        step(3);  gates("startup_dead", 0, 0);
        step(1);  gates("startup_low", 0, 1);

        PWM_sig = 1'b1;
        step(1);  gates("rise_edge", 0, 0);
        step(3);  gates("rise_dead", 0, 0);
        step(1);  gates("rise_drive", 1, 0);

        PWM_sig = 1'b0;
        step(1);  gates("fall_edge", 0, 0);
        step(3);  gates("fall_dead", 0, 0);
        step(1);  gates("fall_drive", 0, 1);

        PWM_sig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1); gates("short_high", 0, 0);
        end
        PWM_sig = 1'b0;
        step(1);  gates("short_fall", 0, 0);
        step(3);  gates("short_dead", 0, 0);
        step(1);  gates("short_low", 0, 1);

        PWM_sig = 1'b1;
        step(5);  gates("oc_setup", 1, 0);
        for (int p = 1; p <= 3; p++) begin
            period(1'b1, 1'b0);
            check("oc_cnt", ovr_cnt, p);
            check("oc_nofault", fault, 0);
        end
        period(1'b1, 1'b0);
        check("trip_cnt", ovr_cnt, 4);
        check("trip_fault", fault, 1);
        gates("trip", 0, 0);

        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        check("clr_fault", fault, 0);
        check("clr_cnt", ovr_cnt, 0);
        gates("rearm", 0, 0);
        step(3);  gates("rearm_wait", 0, 0);
        period(1'b0, 1'b0);
        gates("rearm_synch", 0, 0);
        step(3);  gates("rearm_dead", 0, 0);
        step(1);  gates("rearm_drive", 1, 0);

        period(1'b1, 1'b0); check("pat_p1", ovr_cnt, 1);
        period(1'b1, 1'b0); check("pat_p2", ovr_cnt, 2);
        period(1'b0, 1'b0); check("pat_p3", ovr_cnt, 0);
        period(1'b1, 1'b0); check("pat_p4", ovr_cnt, 1);
        check("pat_nofault", fault, 0);

        OVR_I_blank_n = 1'b0;
        period(1'b1, 1'b0); check("blank_p1", ovr_cnt, 0);
        period(1'b1, 1'b0); check("blank_p2", ovr_cnt, 0);
        OVR_I_blank_n = 1'b1;

        period(1'b1, 1'b0); check("prio_pre", ovr_cnt, 1);
        period(1'b1, 1'b1); check("clr_prio", ovr_cnt, 0);

        run_left = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            run_left--;
            if (run_left == 0) begin
                PWM_sig  = ~PWM_sig;
                run_left = $urandom_range(1, 10);
            end
            OVR_I         = ($urandom_range(0, 2) == 0);
            OVR_I_blank_n = ($urandom_range(0, 7) != 0);
            PWM_synch     = ((i % 12) == 11);
            clr_fault     = ($urandom_range(0, 39) == 0);
            if (i == 1000 || i == 2000) begin
                #2 rst_n = 1'b0;
                #1;
                gates("async_reset", 0, 0);
                check("async_reset_fault", fault, 0);
                check("async_reset_cnt", ovr_cnt, 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
